// File: rtl/cpu_mem_bus_pkg.sv
// Shared types and constants for the cache-controller to memory-bus arbiter.
package cpu_mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam int MEM_ID_W   = 3;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 128;

  // One bus request as seen at the default bus widths (up to 8 ports).
  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [MEM_ID_W-1:0]   id;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/cpu_mem_bus_arb_pick.sv
// Combinational winner picker: lowest index (fixed) or first index at/after rr_ptr (round-robin).
module cpu_mem_bus_arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  rr_ptr,
  input  logic                 rr_mode,
  output logic [ID_WIDTH-1:0]  winner,
  output logic                 any
);

  localparam logic [ID_WIDTH:0] NUM_PORTS_W = (ID_WIDTH+1)'(NUM_PORTS);

  logic [ID_WIDTH:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    winner = '0;
    any    = |req;
    idx    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = rr_mode ? ({1'b0, rr_ptr} + (ID_WIDTH+1)'(k)) : (ID_WIDTH+1)'(k);
      if (idx >= NUM_PORTS_W) idx = idx - NUM_PORTS_W;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[i] && (idx == (ID_WIDTH+1)'(i))) winner = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// N-port arbiter between cache controllers and the shared memory bus, with
// registered request issue and id-routed responses.
module cpu_mem_bus_arbiter
  import cpu_mem_bus_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ARB_MODE   = 0,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [ADDR_WIDTH-1:0]           resp_addr,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            mem_req_read,
  output logic                            mem_req_write,
  output logic [ID_WIDTH-1:0]             mem_req_id,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_data,
  input  logic                            mem_req_ready,
  input  logic                            mem_resp_valid,
  input  logic [ID_WIDTH-1:0]             mem_resp_id,
  input  logic [ADDR_WIDTH-1:0]           mem_resp_addr,
  input  logic [DATA_WIDTH-1:0]           mem_resp_data,
  output logic                            busy,
  output logic                            error,
  output arb_state_e                      dbg_state
);

  localparam logic [ID_WIDTH:0]   NUM_PORTS_W = (ID_WIDTH+1)'(NUM_PORTS);
  localparam logic [ID_WIDTH-1:0] LAST_PORT   = ID_WIDTH'(NUM_PORTS - 1);

  arb_state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
  logic                      rd_q, rd_d, wr_q, wr_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [NUM_PORTS-1:0]      resp_valid_q, resp_valid_d;
  logic [ADDR_WIDTH-1:0]     resp_addr_q, resp_addr_d;
  logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                      error_q, error_d;

  logic                      pick_any;
  logic [ID_WIDTH-1:0]       pick_id;
  logic                      sel_read, sel_write;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      resp_in_range, resp_expected;

  cpu_mem_bus_arb_pick #(
    .NUM_PORTS(NUM_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (req_read | req_write),
    .rr_ptr (rr_ptr_q),
    .rr_mode(ARB_MODE == ARB_RR),
    .winner (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pick_id == ID_WIDTH'(i)) begin
        sel_read  = req_read[i];
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign resp_in_range = ({1'b0, mem_resp_id} < NUM_PORTS_W);
  assign resp_expected = (state_q == WAIT_RESP) && (mem_resp_id == id_q);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    id_d         = id_q;
    addr_d       = addr_q;
    data_d       = data_q;
    resp_valid_d = '0;
    resp_addr_d  = resp_addr_q;
    resp_data_d  = resp_data_q;
    error_d      = error_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = ISSUE;
          rd_d     = sel_read;
          wr_d     = sel_write & ~sel_read;
          id_d     = pick_id;
          addr_d   = sel_addr;
          data_d   = sel_data;
          rr_ptr_d = (pick_id == LAST_PORT) ? '0 : pick_id + 1'b1;
          if (sel_read && sel_write) error_d = 1'b1;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = rd_q ? WAIT_RESP : IDLE;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid && (mem_resp_id == id_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Responses are routed in every state; out-of-range ids are dropped.
    if (mem_resp_valid) begin
      if (!resp_in_range) begin
        error_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (mem_resp_id == ID_WIDTH'(i)) resp_valid_d[i] = 1'b1;
        end
        resp_addr_d = mem_resp_addr;
        resp_data_d = mem_resp_data;
        if (!resp_expected) error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_valid_q <= '0;
      resp_addr_q  <= '0;
      resp_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      id_q         <= id_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_data_q  <= resp_data_d;
      error_q      <= error_d;
    end
  end

  // Acceptance is the only combinational path from an input to an output.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ((state_q == ISSUE) && mem_req_ready && (id_q == ID_WIDTH'(i))) req_ready[i] = 1'b1;
    end
  end

  assign mem_req_read  = rd_q;
  assign mem_req_write = wr_q;
  assign mem_req_id    = id_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;
  assign resp_valid    = resp_valid_q;
  assign resp_addr     = resp_addr_q;
  assign resp_data     = resp_data_q;
  assign busy          = (state_q != IDLE);
  assign error         = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Bench for two arbiter instances: 2-port fixed priority (inst 0) and 4-port round-robin (inst 1).
module tb_cpu_mem_bus_arbiter;
  import cpu_mem_bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int IW = 2;
  localparam int NP   [2] = '{2, 4};
  localparam int MODE [2] = '{0, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst    [2];
  logic [3:0]      rd     [2];
  logic [3:0]      wr     [2];
  logic [4*AW-1:0] ra     [2];
  logic [4*DW-1:0] rdt    [2];
  logic            mrdy   [2];
  logic            rv     [2];
  logic [IW-1:0]   rid    [2];
  logic [AW-1:0]   rsa    [2];
  logic [DW-1:0]   rsd    [2];

  logic [1:0]      a_rr, a_rv;
  logic [3:0]      b_rr, b_rv;
  logic [AW-1:0]   o_raddr [2];
  logic [DW-1:0]   o_rdata [2];
  logic            o_mrd   [2];
  logic            o_mwr   [2];
  logic [IW-1:0]   o_mid   [2];
  logic [AW-1:0]   o_maddr [2];
  logic [DW-1:0]   o_mdata [2];
  logic            o_busy  [2];
  logic            o_err   [2];
  arb_state_e      o_st    [2];

  cpu_mem_bus_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .ID_WIDTH(IW)) dut_a (
    .clock(clk), .reset(rst[0]),
    .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
    .req_addr(ra[0][2*AW-1:0]), .req_data(rdt[0][2*DW-1:0]),
    .req_ready(a_rr), .resp_valid(a_rv), .resp_addr(o_raddr[0]), .resp_data(o_rdata[0]),
    .mem_req_read(o_mrd[0]), .mem_req_write(o_mwr[0]), .mem_req_id(o_mid[0]),
    .mem_req_addr(o_maddr[0]), .mem_req_data(o_mdata[0]), .mem_req_ready(mrdy[0]),
    .mem_resp_valid(rv[0]), .mem_resp_id(rid[0]), .mem_resp_addr(rsa[0]), .mem_resp_data(rsd[0]),
    .busy(o_busy[0]), .error(o_err[0]), .dbg_state(o_st[0])
  );

  cpu_mem_bus_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .ID_WIDTH(IW)) dut_b (
    .clock(clk), .reset(rst[1]),
    .req_read(rd[1]), .req_write(wr[1]), .req_addr(ra[1]), .req_data(rdt[1]),
    .req_ready(b_rr), .resp_valid(b_rv), .resp_addr(o_raddr[1]), .resp_data(o_rdata[1]),
    .mem_req_read(o_mrd[1]), .mem_req_write(o_mwr[1]), .mem_req_id(o_mid[1]),
    .mem_req_addr(o_maddr[1]), .mem_req_data(o_mdata[1]), .mem_req_ready(mrdy[1]),
    .mem_resp_valid(rv[1]), .mem_resp_id(rid[1]), .mem_resp_addr(rsa[1]), .mem_resp_data(rsd[1]),
    .busy(o_busy[1]), .error(o_err[1]), .dbg_state(o_st[1])
  );

  // ---------------- reference model state ----------------
  mem_req_t pend [2][4];
  bit       pv   [2][4];
  int       rrp  [2];
  bit       exp_err [2];
  int       refill_mode;
  int       checks = 0;
  int       errors = 0;

  function automatic logic [3:0] rr_out(int inst);
    return (inst == 0) ? {2'b00, a_rr} : b_rr;
  endfunction

  function automatic logic [3:0] rv_out(int inst);
    return (inst == 0) ? {2'b00, a_rv} : b_rv;
  endfunction

  // Winner = first pending port scanning upward from the rotation base.
  function automatic int exp_winner(int inst);
    int base = (MODE[inst] == 1) ? rrp[inst] : 0;
    for (int k = 0; k < NP[inst]; k++) begin
      int p = (base + k) % NP[inst];
      if (pv[inst][p]) return p;
    end
    return -1;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(int inst, string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL i%0d %s observed=%0h expected=%0h", inst, tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs(int inst);
    for (int p = 0; p < 4; p++) begin
      rd[inst][p] = pv[inst][p] && pend[inst][p].read;
      wr[inst][p] = pv[inst][p] && pend[inst][p].write;
      ra[inst][p*AW +: AW]  = pend[inst][p].addr;
      rdt[inst][p*DW +: DW] = pend[inst][p].data;
    end
  endtask

  // kind: 0 = random op, 1 = write, 2 = read
  task automatic new_req(int inst, int p, int kind);
    mem_req_t r;
    r.read  = (kind == 2) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    r.write = ~r.read;
    r.id    = 3'(p);
    r.addr  = $urandom;
    r.data  = {$urandom, $urandom, $urandom, $urandom};
    pend[inst][p] = r;
    pv[inst][p]   = 1'b1;
  endtask

  task automatic refill(int inst);
    bit any = 1'b0;
    for (int p = 0; p < NP[inst]; p++) begin
      if (!pv[inst][p]) begin
        if (refill_mode == 1 && $urandom_range(0, 1) == 1) new_req(inst, p, 0);
        if (refill_mode == 2) new_req(inst, p, 1);
      end
    end
    for (int p = 0; p < NP[inst]; p++) any |= pv[inst][p];
    if (!any && refill_mode != 0) new_req(inst, $urandom_range(0, NP[inst] - 1), 0);
    drive_inputs(inst);
  endtask

  task automatic reset_checks(int inst);
    chk(inst, "rst_busy", o_busy[inst], 0);
    chk(inst, "rst_err", o_err[inst], 0);
    chk(inst, "rst_state", o_st[inst], IDLE);
    chk(inst, "rst_mrd", o_mrd[inst], 0);
    chk(inst, "rst_mwr", o_mwr[inst], 0);
    chk(inst, "rst_mid", o_mid[inst], 0);
    chk(inst, "rst_maddr", o_maddr[inst], 0);
    chk(inst, "rst_mdata", o_mdata[inst], 0);
    chk(inst, "rst_rdy", rr_out(inst), 0);
    chk(inst, "rst_rv", rv_out(inst), 0);
    chk(inst, "rst_raddr", o_raddr[inst], 0);
    chk(inst, "rst_rdata", o_rdata[inst], 0);
  endtask

  task automatic do_reset(int inst);
    rst[inst] = 1'b1;
    tick();
    rst[inst] = 1'b0;
    rrp[inst] = 0;
    exp_err[inst] = 1'b0;
    reset_checks(inst);
  endtask

  // One full transaction. Entry: FSM idle, pending requests driven.
  task automatic txn(int inst, int d, int rdly, logic [DW-1:0] resp_d);
    int       w;
    mem_req_t r;
    w = exp_winner(inst);
    if (w < 0) begin
      chk(inst, "no_pending", 0, 1);
      return;
    end
    r = pend[inst][w];
    tick();
    chk(inst, "grant_busy", o_busy[inst], 1);
    chk(inst, "grant_id", o_mid[inst], w);
    chk(inst, "grant_rd", o_mrd[inst], r.read);
    chk(inst, "grant_wr", o_mwr[inst], r.write);
    chk(inst, "grant_addr", o_maddr[inst], r.addr);
    chk(inst, "grant_data", o_mdata[inst], r.data);
    chk(inst, "resp_quiet", rv_out(inst), 0);
    rrp[inst] = (w + 1) % NP[inst];
    if (d < 0) d = $urandom_range(0, 3);
    for (int c = 0; c < d; c++) begin
      mrdy[inst] = 1'b0;
      ra[inst][w*AW +: AW] = $urandom;
      #1;
      chk(inst, "rdy_low", rr_out(inst), 0);
      tick();
      chk(inst, "hold_addr", o_maddr[inst], r.addr);
      chk(inst, "hold_strobe", o_mrd[inst] | o_mwr[inst], 1);
    end
    mrdy[inst] = 1'b1;
    #1;
    chk(inst, "rdy_pulse", rr_out(inst), 4'(1) << w);
    tick();
    mrdy[inst] = 1'b0;
    pv[inst][w] = 1'b0;
    drive_inputs(inst);
    chk(inst, "acc_strobe", {o_mrd[inst], o_mwr[inst]}, 0);
    if (!r.read) begin
      chk(inst, "wr_bubble", o_busy[inst], 0);
      refill(inst);
    end else begin
      chk(inst, "wait_busy", o_busy[inst], 1);
      if (rdly < 0) rdly = $urandom_range(0, 3);
      for (int c = 0; c < rdly; c++) begin
        tick();
        chk(inst, "wait_hold", o_busy[inst], 1);
        chk(inst, "wait_norv", rv_out(inst), 0);
      end
      rv[inst]  = 1'b1;
      rid[inst] = IW'(w);
      rsa[inst] = $urandom;
      rsd[inst] = resp_d;
      tick();
      rv[inst] = 1'b0;
      chk(inst, "resp_valid", rv_out(inst), 4'(1) << w);
      chk(inst, "resp_addr", o_raddr[inst], rsa[inst]);
      chk(inst, "resp_data", o_rdata[inst], resp_d);
      chk(inst, "resp_idle", o_busy[inst], 0);
      refill(inst);
    end
    chk(inst, "err_flag", o_err[inst], exp_err[inst]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd[i] = '0; wr[i] = '0; ra[i] = '0; rdt[i] = '0;
      mrdy[i] = 1'b0; rv[i] = 1'b0; rid[i] = '0; rsa[i] = '0; rsd[i] = '0;
      rrp[i] = 0; exp_err[i] = 1'b0;
      for (int p = 0; p < 4; p++) begin
        pv[i][p] = 1'b0;
        pend[i][p] = '0;
      end
    end
    refill_mode = 0;
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    reset_checks(0);
    reset_checks(1);

    // Fixed priority: both ports read together, port 0 first, port 1 after its response.
    new_req(0, 0, 2);
    new_req(0, 1, 2);
    drive_inputs(0);
    txn(0, 0, -1, {$urandom, $urandom, $urandom, $urandom});
    txn(0, 0, -1, {$urandom, $urandom, $urandom, $urandom});

    // Port 1 read at 0x40, memory stalls three cycles.
    new_req(0, 1, 2);
    pend[0][1].addr = 32'h40;
    drive_inputs(0);
    txn(0, 3, 2, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);

    // Out-of-range response id is dropped and raises a sticky error.
    rv[0] = 1'b1; rid[0] = 2'd3; rsd[0] = {4{$urandom}};
    tick();
    rv[0] = 1'b0;
    chk(0, "oor_no_rv", rv_out(0), 0);
    chk(0, "oor_err", o_err[0], 1);
    tick();
    chk(0, "oor_sticky", o_err[0], 1);
    do_reset(0);

    // Unsolicited response in IDLE is still routed.
    rv[0] = 1'b1; rid[0] = 2'd0; rsa[0] = $urandom; rsd[0] = {4{$urandom}};
    tick();
    rv[0] = 1'b0;
    chk(0, "unsol_rv", rv_out(0), 4'b0001);
    chk(0, "unsol_data", o_rdata[0], rsd[0]);
    chk(0, "unsol_err", o_err[0], 1);
    do_reset(0);

    // Read and write asserted together on port 0 issues as a read.
    rd[0][0] = 1'b1; wr[0][0] = 1'b1;
    tick();
    chk(0, "rw_read", o_mrd[0], 1);
    chk(0, "rw_write", o_mwr[0], 0);
    chk(0, "rw_id", o_mid[0], 0);
    chk(0, "rw_err", o_err[0], 1);
    mrdy[0] = 1'b1;
    #1;
    chk(0, "rw_ready", rr_out(0), 4'b0001);
    tick();
    mrdy[0] = 1'b0; rd[0] = '0; wr[0] = '0;
    chk(0, "rw_wait", o_busy[0], 1);

    // Reset in WAIT_RESP abandons the read; the late response is then unsolicited.
    do_reset(0);
    rv[0] = 1'b1; rid[0] = 2'd0; rsd[0] = {4{$urandom}};
    tick();
    rv[0] = 1'b0;
    chk(0, "late_err", o_err[0], 1);
    chk(0, "late_rv", rv_out(0), 4'b0001);
    do_reset(0);

    // Random traffic on the fixed-priority instance.
    refill_mode = 1;
    refill(0);
    for (int n = 0; n < 25; n++) txn(0, -1, -1, {$urandom, $urandom, $urandom, $urandom});

    // Round-robin: all four ports hold writes, grants rotate 0,1,2,3,0.
    refill_mode = 2;
    refill(1);
    for (int n = 0; n < 5; n++) txn(1, 0, -1, '0);

    // Random traffic on the round-robin instance.
    refill_mode = 1;
    for (int p = 0; p < 4; p++) pv[1][p] = 1'b0;
    refill(1);
    for (int n = 0; n < 30; n++) txn(1, -1, -1, {$urandom, $urandom, $urandom, $urandom});

    // Reset mid-read on the round-robin instance, then check rotation restarts at port 0.
    refill_mode = 0;
    for (int p = 0; p < 4; p++) pv[1][p] = 1'b0;
    drive_inputs(1);
    tick();
    new_req(1, 2, 2);
    drive_inputs(1);
    tick();
    chk(1, "mid_grant", o_mid[1], 2);
    mrdy[1] = 1'b1;
    tick();
    mrdy[1] = 1'b0;
    pv[1][2] = 1'b0;
    drive_inputs(1);
    chk(1, "mid_wait", o_busy[1], 1);
    do_reset(1);
    rv[1] = 1'b1; rid[1] = 2'd2; rsd[1] = {4{$urandom}};
    tick();
    rv[1] = 1'b0;
    chk(1, "mid_late_err", o_err[1], 1);
    chk(1, "mid_late_rv", rv_out(1), 4'b0100);
    do_reset(1);
    refill_mode = 2;
    refill(1);
    for (int n = 0; n < 4; n++) txn(1, -1, -1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bus_arbiter.md
# cpu_mem_bus_arbiter

Parametrised N-port arbiter between the core's cache controllers (icache, dcache, and future ports such as a page-table walker or prefetcher) and the single shared memory bus. It replaces the latch-based two-port request balancer and response dispatcher inside the core. It adds a registered request path, a selectable arbitration mode and per-port acceptance handshakes. It also routes each response strictly by transaction id.

## Interface
- NUM_PORTS, 2, number of requesting ports (2..8); port 0 = dcache
- ADDR_WIDTH, 32, bus address width
- DATA_WIDTH, 128, bus data width (one cache line)
- ARB_MODE, 0, 0 = fixed priority (lower index wins), 1 = round-robin
- ID_WIDTH, $clog2(NUM_PORTS) (min 1), transaction id width
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_read  in  NUM_PORTS  per-port read request, held until accepted
- req_write  in  NUM_PORTS  per-port write request, held until accepted
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_PORTS*DATA_WIDTH  per-port write data, same packing
- req_ready  out  NUM_PORTS  one-cycle pulse: that port's request was accepted by memory
- resp_valid  out  NUM_PORTS  one-cycle pulse: response for that port
- resp_addr  out  ADDR_WIDTH  response address, shared by all ports
- resp_data  out  DATA_WIDTH  response data, shared by all ports
- mem_req_read / mem_req_write  out  1  bus request strobes
- mem_req_id  out  ID_WIDTH  index of the granted port
- mem_req_addr / mem_req_data  out  ADDR_WIDTH / DATA_WIDTH  granted request payload
- mem_req_ready  in  1  memory accepts the current request this cycle
- mem_resp_valid  in  1  memory response strobe
- mem_resp_id / mem_resp_addr / mem_resp_data  in  ID_WIDTH / ADDR_WIDTH / DATA_WIDTH  response payload
- busy  out  1  FSM not in IDLE
- error  out  1  sticky protocol-error flag; cleared only by reset

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any port asserts req_read or req_write, select a winner and latch its id, op, addr and data into the mem_req_* registers. Go to ISSUE.
- Winner selection:
  - ARB_MODE=0: the lowest requesting index wins.
  - ARB_MODE=1: the first requesting index at or after rr_ptr, modulo NUM_PORTS, wins. rr_ptr is set to winner+1 (wrapping to 0 past NUM_PORTS-1) on every grant.
- ISSUE:
  - mem_req_read/write are held until mem_req_ready.
  - req_ready[grant] = (state==ISSUE && mem_req_ready), combinational.
  - On acceptance, a read goes to WAIT_RESP. A write goes to IDLE and expects no response.
- WAIT_RESP:
  - On mem_resp_valid with mem_resp_id==grant, go to IDLE.
- Response routing (every state):
  - Any mem_resp_valid with mem_resp_id < NUM_PORTS is registered into resp_valid[mem_resp_id], resp_addr and resp_data.
  - A response with mem_resp_id >= NUM_PORTS is dropped and sets error.
  - An unsolicited response (not in WAIT_RESP, or id != grant) is still routed and sets error.
- A port asserting req_read and req_write together is treated as a read and sets error.
- The winning port must hold its request until req_ready. Request changes during ISSUE are ignored, because the payload was latched in IDLE.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE and rr_ptr = 0.
  - Any outstanding transaction is abandoned.
- A reset asserted mid-transaction takes effect at the next edge regardless of state.
- Request latency: a request seen in IDLE at edge N drives mem_req_* from edge N+1. Minimum request-to-req_ready is 1 cycle (mem_req_ready already high in the first ISSUE cycle).
- Back-to-back: after a write is accepted the FSM returns to IDLE. The next grant is latched one cycle later, so there is one bubble between transactions.
- Response latency: mem_resp_valid at edge N produces resp_valid at edge N+1 for exactly one cycle.
- The response that closes a read and a new request in the same cycle: the FSM reaches IDLE at N+1 and arbitrates from N+1.
- mem_req_* and resp_* are driven directly from flops. There is no combinational input-to-output path except req_ready.

## Structure
- Shared package cpu_mem_bus_pkg holds:
  - the state enum arb_state_e (IDLE, ISSUE, WAIT_RESP);
  - the ARB_FIXED / ARB_RR mode constants;
  - a mem_req_t struct (read, write, id, addr, data).
- One sub-module, cpu_mem_bus_arb_pick: a purely combinational priority / round-robin picker. It takes a request vector, rr_ptr and the mode, and returns a winner index plus an any-request flag. This lets it be unit-tested alone.

## Test plan
- NUM_PORTS=2, ARB_MODE=0; both ports read in the same cycle, mem_req_ready=1 -> port 0 granted first (mem_req_id=0), port 1 granted only after port 0's response with id 0.
- NUM_PORTS=4, ARB_MODE=1; all ports hold writes, mem_req_ready=1 -> grant order 0,1,2,3,0 with one bubble between grants, and req_ready pulses once per grant.
- Read on port 1 at addr 0x40, mem_req_ready held low 3 cycles, then a response with id=1 and data 0xDEADBEEF… -> req_ready[1] pulses on the 4th ISSUE cycle, then resp_valid[1]=1 for one cycle with that data while resp_valid[0] stays 0.
- mem_resp_valid with id=3 when NUM_PORTS=2 -> no resp_valid pulse and error=1 until reset; an unsolicited id=0 response in IDLE -> resp_valid[0] pulses and error=1.
- Reset asserted during WAIT_RESP -> next cycle busy=0, all outputs 0, rr_ptr=0; a late response then sets error.
- Port 0 asserts req_read and req_write together -> issued as a read (mem_req_read=1, mem_req_write=0) and error=1.
